// File: rtl/shared_iter_unit_arbiter.sv
`default_nettype none
// =============================================================================
// Module : shared_iter_unit_arbiter
// Round-robin owner of one shared iterative div/sqrt unit (port 0 int, port 1 FP)
// Rev    : 1.0
// =============================================================================
module shared_iter_unit_arbiter #(
   parameter int DATA_WIDTH = 64,
   parameter int CMD_WIDTH  = 4,
   parameter int MAX_CYCLES = 64,
   parameter int CNT_WIDTH  = 7
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic [1:0]            req_valid,
   input  logic [CMD_WIDTH-1:0]  req_cmd0,
   input  logic [CMD_WIDTH-1:0]  req_cmd1,
   input  logic [DATA_WIDTH-1:0] req_src1_0,
   input  logic [DATA_WIDTH-1:0] req_src2_0,
   input  logic [DATA_WIDTH-1:0] req_src1_1,
   input  logic [DATA_WIDTH-1:0] req_src2_1,
   output logic [1:0]            req_ready,
   output logic [1:0]            resp_valid,
   output logic [DATA_WIDTH-1:0] resp_data,
   input  logic [1:0]            resp_ready,
   output logic                  unit_start,
   output logic [CMD_WIDTH-1:0]  unit_cmd,
   output logic [DATA_WIDTH-1:0] unit_src1,
   output logic [DATA_WIDTH-1:0] unit_src2,
   output logic                  unit_flush,
   input  logic                  unit_done,
   input  logic [DATA_WIDTH-1:0] unit_result,
   output logic                  busy,
   output logic                  timeout
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      BUSY  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] c_cntLast = CNT_WIDTH'(MAX_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] c_cntSat  = {CNT_WIDTH{1'b1}};

   state_t                r_state;
   state_t                w_stateNext;
   logic                  r_rrPtr;
   logic                  r_owner;
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic                  r_timeout;
   logic                  r_unitFlush;
   logic [CMD_WIDTH-1:0]  r_unitCmd;
   logic [DATA_WIDTH-1:0] r_unitSrc1;
   logic [DATA_WIDTH-1:0] r_unitSrc2;
   logic [DATA_WIDTH-1:0] r_respData;

   logic w_grant;
   logic w_grantPort;
   logic w_killUnit;
   logic w_setTimeout;
   logic w_latchResult;
   logic w_release;

   // The round-robin favourite wins only when it is actually requesting.
   assign w_grantPort = req_valid[r_rrPtr] ? r_rrPtr : ~r_rrPtr;

   always_comb begin
      w_stateNext   = r_state;
      w_grant       = 1'b0;
      w_killUnit    = 1'b0;
      w_setTimeout  = 1'b0;
      w_latchResult = 1'b0;
      w_release     = 1'b0;
      case (r_state)
         IDLE: begin
            if (!flush && (req_valid != 2'b00)) begin
               w_grant     = 1'b1;
               w_stateNext = START;
            end
         end
         START: begin
            w_stateNext = flush ? IDLE : BUSY;
         end
         BUSY: begin
            if (flush) begin
               w_killUnit  = 1'b1;
               w_stateNext = IDLE;
            end else if (unit_done) begin
               w_latchResult = 1'b1;
               w_stateNext   = HOLD;
            end else if (r_cnt == c_cntLast) begin
               w_setTimeout = 1'b1;
               w_killUnit   = 1'b1;
               w_stateNext  = IDLE;
            end
         end
         HOLD: begin
            if (flush) begin
               w_stateNext = IDLE;
            end else if (resp_ready[r_owner]) begin
               w_release   = 1'b1;
               w_stateNext = IDLE;
            end
         end
         default: w_stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_rrPtr     <= 1'b0;
         r_owner     <= 1'b0;
         r_cnt       <= '0;
         r_timeout   <= 1'b0;
         r_unitFlush <= 1'b0;
         r_unitCmd   <= '0;
         r_unitSrc1  <= '0;
         r_unitSrc2  <= '0;
         r_respData  <= '0;
      end else begin
         r_state     <= w_stateNext;
         r_unitFlush <= w_killUnit;
         if (w_grant) begin
            r_owner    <= w_grantPort;
            r_unitCmd  <= w_grantPort ? req_cmd1   : req_cmd0;
            r_unitSrc1 <= w_grantPort ? req_src1_1 : req_src1_0;
            r_unitSrc2 <= w_grantPort ? req_src2_1 : req_src2_0;
         end
         if (r_state == START) begin
            r_cnt <= '0;
         end else if ((r_state == BUSY) && (r_cnt != c_cntSat)) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_latchResult) begin
            r_respData <= unit_result;
         end
         if (w_setTimeout) begin
            r_timeout <= 1'b1;
         end
         if (w_release) begin
            r_rrPtr <= ~r_owner;
         end
      end
   end

   assign req_ready  = {w_grant & w_grantPort, w_grant & ~w_grantPort};
   assign resp_valid = {(r_state == HOLD) & r_owner, (r_state == HOLD) & ~r_owner};
   assign resp_data  = r_respData;
   // A flush arriving in START must stop the pulse in the same cycle.
   assign unit_start = (r_state == START) & ~flush;
   assign unit_cmd   = r_unitCmd;
   assign unit_src1  = r_unitSrc1;
   assign unit_src2  = r_unitSrc2;
   assign unit_flush = r_unitFlush;
   assign busy       = (r_state != IDLE);
   assign timeout    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_shared_iter_unit_arbiter.sv
`default_nettype none
// =============================================================================
// Module : tb_shared_iter_unit_arbiter
// Scoreboard bench for the shared iterative-unit arbiter
// Rev    : 1.0
// =============================================================================
module tb_shared_iter_unit_arbiter;
   localparam int DW = 64;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic [1:0]    req_valid;
   logic [CW-1:0] req_cmd0, req_cmd1;
   logic [DW-1:0] req_src1_0, req_src2_0, req_src1_1, req_src2_1;
   logic [1:0]    req_ready;
   logic [1:0]    resp_valid;
   logic [DW-1:0] resp_data;
   logic [1:0]    resp_ready;
   logic          unit_start;
   logic [CW-1:0] unit_cmd;
   logic [DW-1:0] unit_src1, unit_src2;
   logic          unit_flush;
   logic          unit_done;
   logic [DW-1:0] unit_result;
   logic          busy;
   logic          timeout;

   int vecs = 0;
   int errs = 0;
   logic [DW:0] sbQ[$];

   always #5 clk = ~clk;

   shared_iter_unit_arbiter #(
      .DATA_WIDTH(DW), .CMD_WIDTH(CW), .MAX_CYCLES(64), .CNT_WIDTH(7)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid),
      .req_cmd0(req_cmd0), .req_cmd1(req_cmd1),
      .req_src1_0(req_src1_0), .req_src2_0(req_src2_0),
      .req_src1_1(req_src1_1), .req_src2_1(req_src2_1),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
      .resp_ready(resp_ready), .unit_start(unit_start), .unit_cmd(unit_cmd),
      .unit_src1(unit_src1), .unit_src2(unit_src2), .unit_flush(unit_flush),
      .unit_done(unit_done), .unit_result(unit_result), .busy(busy), .timeout(timeout)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; flush = 1'b0; req_valid = 2'b00; resp_ready = 2'b00;
      req_cmd0 = '0; req_cmd1 = '0;
      req_src1_0 = '0; req_src2_0 = '0; req_src1_1 = '0; req_src2_1 = '0;
      unit_done = 1'b0; unit_result = '0;
      step(); step();
      rst = 1'b1;
      step();
   endtask

   task automatic test_reset();
      do_reset();
      rst = 1'b0;
      step();
      vecs++;
      if ({busy, timeout, unit_start, unit_flush, resp_valid, req_ready} !== 8'h00) begin
         errs++;
         $display("FAIL reset_ctrl got=%b exp=00000000",
                  {busy, timeout, unit_start, unit_flush, resp_valid, req_ready});
      end
      vecs++;
      if ({unit_cmd, unit_src1, unit_src2, resp_data} !== '0) begin
         errs++;
         $display("FAIL reset_data cmd=%h src1=%h src2=%h resp=%h exp=all zero",
                  unit_cmd, unit_src1, unit_src2, resp_data);
      end
      rst = 1'b1;
      step();
      vecs++;
      if (busy !== 1'b0) begin
         errs++; $display("FAIL reset_release_busy got=%b exp=0", busy);
      end
   endtask

   task automatic test_single();
      logic [DW:0] exp;
      int n;
      do_reset();
      req_valid = 2'b01; req_cmd0 = 4'd3; req_src1_0 = 64'd100; req_src2_0 = 64'd7;
      #1;
      vecs++;
      if (req_ready !== 2'b01) begin
         errs++; $display("FAIL single_grant got=%b exp=01", req_ready);
      end
      step();
      req_valid = 2'b00;
      #1;
      vecs++;
      if (unit_start !== 1'b1) begin
         errs++; $display("FAIL single_start got=%b exp=1", unit_start);
      end
      vecs++;
      if ({unit_cmd, unit_src1, unit_src2} !== {4'd3, 64'd100, 64'd7}) begin
         errs++;
         $display("FAIL single_operands cmd=%0d src1=%0d src2=%0d exp=3/100/7",
                  unit_cmd, unit_src1, unit_src2);
      end
      vecs++;
      if (req_ready !== 2'b00) begin
         errs++; $display("FAIL single_ready_pulse got=%b exp=00", req_ready);
      end
      for (int i = 1; i <= 5; i++) begin
         if (i == 5) begin
            unit_done = 1'b1; unit_result = 64'd14;
            sbQ.push_back({1'b0, 64'd14});
         end
         step();
         if (i < 5) begin
            vecs++;
            if (unit_start !== 1'b0 || busy !== 1'b1) begin
               errs++;
               $display("FAIL single_busy_cycle%0d start=%b busy=%b exp=0/1", i, unit_start, busy);
            end
         end
      end
      unit_done = 1'b0;
      n = 0;
      while (resp_valid === 2'b00 && n < 20) begin step(); n++; end
      vecs++;
      if (sbQ.size() == 0) begin
         errs++; $display("FAIL single_scoreboard_empty size=0 exp=1");
      end else begin
         exp = sbQ.pop_front();
         if (resp_valid !== (exp[DW] ? 2'b10 : 2'b01) || resp_data !== exp[DW-1:0]) begin
            errs++;
            $display("FAIL single_resp valid=%b data=%0d exp=%b/%0d",
                     resp_valid, resp_data, (exp[DW] ? 2'b10 : 2'b01), exp[DW-1:0]);
         end
      end
      resp_ready = 2'b01;
      step();
      resp_ready = 2'b00;
      vecs++;
      if (busy !== 1'b0 || resp_valid !== 2'b00) begin
         errs++; $display("FAIL single_release busy=%b valid=%b exp=0/00", busy, resp_valid);
      end
   endtask

   task automatic test_round_robin();
      logic [DW:0] exp;
      int order[3];
      int n;
      logic op;
      order[0] = 0; order[1] = 1; order[2] = 0;
      do_reset();
      req_valid = 2'b11;
      req_cmd0 = 4'd1; req_src1_0 = 64'd10; req_src2_0 = 64'd11;
      req_cmd1 = 4'd2; req_src1_1 = 64'd20; req_src2_1 = 64'd21;
      for (int k = 0; k < 3; k++) begin
         op = (order[k] == 1);
         #1;
         vecs++;
         if (req_ready !== (op ? 2'b10 : 2'b01)) begin
            errs++;
            $display("FAIL rr_grant%0d got=%b exp=%b", k, req_ready, (op ? 2'b10 : 2'b01));
         end
         step();
         vecs++;
         if (unit_cmd !== (op ? 4'd2 : 4'd1) || unit_src1 !== (op ? 64'd20 : 64'd10)) begin
            errs++;
            $display("FAIL rr_operands%0d cmd=%0d src1=%0d exp=%0d/%0d", k, unit_cmd, unit_src1,
                     (op ? 2 : 1), (op ? 20 : 10));
         end
         step();
         vecs++;
         if (req_ready !== 2'b00) begin
            errs++; $display("FAIL rr_no_grant_busy%0d got=%b exp=00", k, req_ready);
         end
         unit_done = 1'b1; unit_result = 64'(1000 + k);
         sbQ.push_back({op, 64'(1000 + k)});
         step();
         unit_done = 1'b0;
         n = 0;
         while (resp_valid === 2'b00 && n < 20) begin step(); n++; end
         vecs++;
         if (sbQ.size() == 0) begin
            errs++; $display("FAIL rr_scoreboard_empty%0d size=0 exp=1", k);
         end else begin
            exp = sbQ.pop_front();
            if (resp_valid !== (exp[DW] ? 2'b10 : 2'b01) || resp_data !== exp[DW-1:0]) begin
               errs++;
               $display("FAIL rr_resp%0d valid=%b data=%0d exp=%b/%0d", k, resp_valid,
                        resp_data, (exp[DW] ? 2'b10 : 2'b01), exp[DW-1:0]);
            end
         end
         resp_ready = (op ? 2'b10 : 2'b01);
         step();
         resp_ready = 2'b00;
      end
      req_valid = 2'b00;
   endtask

   task automatic test_flush();
      do_reset();
      req_valid = 2'b01; req_cmd0 = 4'd5;
      step();
      req_valid = 2'b00; flush = 1'b1;
      #1;
      vecs++;
      if (unit_start !== 1'b0) begin
         errs++; $display("FAIL flush_start_suppress got=%b exp=0", unit_start);
      end
      step();
      flush = 1'b0;
      vecs++;
      if (busy !== 1'b0) begin
         errs++; $display("FAIL flush_start_idle busy=%b exp=0", busy);
      end
      req_valid = 2'b01;
      step();
      req_valid = 2'b00;
      step();
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      vecs++;
      if (unit_flush !== 1'b1 || busy !== 1'b0 || resp_valid !== 2'b00) begin
         errs++;
         $display("FAIL flush_busy_kill uflush=%b busy=%b valid=%b exp=1/0/00",
                  unit_flush, busy, resp_valid);
      end
      unit_done = 1'b1; unit_result = 64'd55;
      step();
      unit_done = 1'b0;
      vecs++;
      if (unit_flush !== 1'b0 || busy !== 1'b0 || resp_valid !== 2'b00) begin
         errs++;
         $display("FAIL flush_late_done uflush=%b busy=%b valid=%b exp=0/0/00",
                  unit_flush, busy, resp_valid);
      end
      step();
      vecs++;
      if (resp_valid !== 2'b00) begin
         errs++; $display("FAIL flush_no_resp got=%b exp=00", resp_valid);
      end
      req_valid = 2'b11;
      #1;
      vecs++;
      if (req_ready !== 2'b01) begin
         errs++; $display("FAIL flush_rr_kept got=%b exp=01", req_ready);
      end
      step();
      req_valid = 2'b00; flush = 1'b1;
      step();
      flush = 1'b0;
   endtask

   task automatic test_hold_stall();
      logic [DW:0] exp;
      logic [DW-1:0] expData;
      do_reset();
      expData = 64'hDEAD_BEEF_0123_4567;
      req_valid = 2'b10; req_cmd1 = 4'd9; req_src1_1 = 64'd42; req_src2_1 = 64'd6;
      #1;
      vecs++;
      if (req_ready !== 2'b10) begin
         errs++; $display("FAIL hold_grant_port1 got=%b exp=10", req_ready);
      end
      step();
      req_valid = 2'b00;
      step();
      unit_done = 1'b1; unit_result = expData;
      sbQ.push_back({1'b1, expData});
      step();
      unit_done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         vecs++;
         if (resp_valid !== 2'b10 || resp_data !== expData) begin
            errs++;
            $display("FAIL hold_stall%0d valid=%b data=%h exp=10/%h", i, resp_valid, resp_data, expData);
         end
         if (i == 3) begin
            unit_done = 1'b1; unit_result = 64'h1111_2222_3333_4444;
         end else begin
            unit_done = 1'b0;
         end
         step();
      end
      unit_done = 1'b0;
      resp_ready = 2'b01;
      step();
      vecs++;
      if (resp_valid !== 2'b10 || busy !== 1'b1) begin
         errs++; $display("FAIL hold_wrong_port valid=%b busy=%b exp=10/1", resp_valid, busy);
      end
      resp_ready = 2'b10;
      vecs++;
      if (sbQ.size() == 0) begin
         errs++; $display("FAIL hold_scoreboard_empty size=0 exp=1");
      end else begin
         exp = sbQ.pop_front();
         if (resp_valid !== (exp[DW] ? 2'b10 : 2'b01) || resp_data !== exp[DW-1:0]) begin
            errs++;
            $display("FAIL hold_resp valid=%b data=%h exp=%b/%h", resp_valid, resp_data,
                     (exp[DW] ? 2'b10 : 2'b01), exp[DW-1:0]);
         end
      end
      step();
      resp_ready = 2'b00;
      vecs++;
      if (resp_valid !== 2'b00 || busy !== 1'b0) begin
         errs++; $display("FAIL hold_release valid=%b busy=%b exp=00/0", resp_valid, busy);
      end
   endtask

   task automatic test_timeout();
      int n;
      do_reset();
      req_valid = 2'b01;
      step();
      req_valid = 2'b00;
      step();
      vecs++;
      if (timeout !== 1'b0 || busy !== 1'b1) begin
         errs++; $display("FAIL timeout_pre to=%b busy=%b exp=0/1", timeout, busy);
      end
      n = 0;
      while (busy === 1'b1 && n < 200) begin step(); n++; end
      vecs++;
      if (n != 64) begin
         errs++; $display("FAIL timeout_cycles got=%0d exp=64", n);
      end
      vecs++;
      if (timeout !== 1'b1 || unit_flush !== 1'b1 || busy !== 1'b0) begin
         errs++;
         $display("FAIL timeout_fire to=%b uflush=%b busy=%b exp=1/1/0", timeout, unit_flush, busy);
      end
      step();
      vecs++;
      if (unit_flush !== 1'b0) begin
         errs++; $display("FAIL timeout_flush_pulse got=%b exp=0", unit_flush);
      end
      step(); step(); step();
      vecs++;
      if (timeout !== 1'b1) begin
         errs++; $display("FAIL timeout_sticky got=%b exp=1", timeout);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      req_valid = 2'b01;
      step();
      req_valid = 2'b00;
      step();
      unit_done = 1'b1; unit_result = 64'd77;
      step();
      unit_done = 1'b0;
      resp_ready = 2'b01;
      step();
      resp_ready = 2'b00;
      req_valid = 2'b01; req_cmd0 = 4'hA; req_src1_0 = 64'd500;
      step();
      req_valid = 2'b00;
      step();
      step();
      vecs++;
      if (busy !== 1'b1 || unit_cmd !== 4'hA) begin
         errs++; $display("FAIL areset_pre busy=%b cmd=%h exp=1/a", busy, unit_cmd);
      end
      #2;
      rst = 1'b0;
      #1;
      vecs++;
      if ({busy, timeout, unit_start, unit_flush, resp_valid, req_ready} !== 8'h00 ||
          {unit_cmd, unit_src1, unit_src2, resp_data} !== '0) begin
         errs++;
         $display("FAIL areset_outputs ctrl=%b cmd=%h src1=%0d resp=%0d exp=all zero",
                  {busy, timeout, unit_start, unit_flush, resp_valid, req_ready},
                  unit_cmd, unit_src1, resp_data);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      req_valid = 2'b11;
      #1;
      vecs++;
      if (req_ready !== 2'b01) begin
         errs++; $display("FAIL areset_rr_restart got=%b exp=01", req_ready);
      end
      step();
      req_valid = 2'b00; flush = 1'b1;
      step();
      flush = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL sim_time_limit reached=%0t exp=earlier finish", $time);
      $fatal(1, "simulation time limit");
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_flush();
      test_hold_stall();
      test_timeout();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
`default_nettype wire
